// File: rtl/dual_issue_scoreboard_pkg.sv
// Shared types and helpers for the dual-issue SPU issue scoreboard.
package spu_sched_pkg;
   localparam int NUM_REGS = 128;
   localparam int ADDR_W   = 7;
   localparam int LAT_W    = 3;
   localparam int PERF_W   = 32;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] rb;
      logic [ADDR_W-1:0] rc;
      logic              use_ra;
      logic              use_rb;
      logic              use_rc;
      logic [ADDR_W-1:0] rt;
      logic              wr;
      logic [LAT_W-1:0]  lat;
   } slot_t;

   typedef struct packed {
      slot_t s1;
      slot_t s2;
   } pair_t;

   typedef enum logic [1:0] {EMPTY, PAIR, SECOND} sb_state_e;

   // RAW on any used source or WAW on the destination; empty slots never stall.
   function automatic logic slot_hazard(slot_t s, logic [NUM_REGS-1:0] busy);
      logic raw;
      logic waw;
      raw = (s.use_ra & busy[s.ra]) | (s.use_rb & busy[s.rb]) | (s.use_rc & busy[s.rc]);
      waw = s.wr & busy[s.rt];
      return s.valid & (raw | waw);
   endfunction

   function automatic logic intra_dep(slot_t a, slot_t b);
      return a.wr & ((b.use_ra & (b.ra == a.rt)) | (b.use_rb & (b.rb == a.rt)) |
                     (b.use_rc & (b.rc == a.rt)) | (b.wr & (b.rt == a.rt)));
   endfunction

   function automatic logic [LAT_W-1:0] eff_lat(logic [LAT_W-1:0] lat);
      return (lat == '0) ? LAT_W'(1) : lat;
   endfunction
endpackage

// File: rtl/dual_issue_scoreboard_if.sv
// Decoder-facing and issue-facing signals of the dual-issue scoreboard.
interface dual_issue_scoreboard_if;
   import spu_sched_pkg::*;

   logic                flush;
   logic                dec_valid;
   logic                dec_ready;
   pair_t               dec_pair;
   logic                issue1;
   logic                issue2;
   logic [ADDR_W-1:0]   issue_rt1;
   logic [ADDR_W-1:0]   issue_rt2;
   logic [NUM_REGS-1:0] busy_vec;
   logic [PERF_W-1:0]   stall_cycles;

   modport master (
      output flush, dec_valid, dec_pair,
      input  dec_ready, issue1, issue2, issue_rt1, issue_rt2, busy_vec, stall_cycles
   );

   modport slave (
      input  flush, dec_valid, dec_pair,
      output dec_ready, issue1, issue2, issue_rt1, issue_rt2, busy_vec, stall_cycles
   );
endinterface

// File: rtl/dual_issue_scoreboard_cnt_array.sv
// Per-register result-latency countdowns; a register is busy while its count is non-zero.
module scoreboard_cnt_array
   import spu_sched_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                ld1_en,
   input  logic [ADDR_W-1:0]   ld1_rt,
   input  logic [LAT_W-1:0]    ld1_lat,
   input  logic                ld2_en,
   input  logic [ADDR_W-1:0]   ld2_rt,
   input  logic [LAT_W-1:0]    ld2_lat,
   output logic [NUM_REGS-1:0] busy_vec
);
   logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q;
   logic [NUM_REGS-1:0][LAT_W-1:0] cnt_d;

   // A load overrides the decrement; slot 2 is applied last so it wins a tie.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
         if (ld1_en && (ld1_rt == ADDR_W'(r))) cnt_d[r] = eff_lat(ld1_lat);
         if (ld2_en && (ld2_rt == ADDR_W'(r))) cnt_d[r] = eff_lat(ld2_lat);
         busy_vec[r] = (cnt_q[r] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/dual_issue_scoreboard.sv
// Holds one decoded pair, issues its slots in order once RAW/WAW hazards clear.
module dual_issue_scoreboard
   import spu_sched_pkg::*;
(
   input logic                     clk,
   input logic                     reset,
   dual_issue_scoreboard_if.slave  bus
);
   sb_state_e           state_q, state_d;
   pair_t               pair_q, pair_d;
   logic [PERF_W-1:0]   stall_q, stall_d;
   logic [NUM_REGS-1:0] busy;
   logic                haz1, haz2, intra;
   logic                issue1, issue2, done1, done, ready;

   always_comb begin
      haz1    = slot_hazard(pair_q.s1, busy);
      haz2    = slot_hazard(pair_q.s2, busy);
      intra   = intra_dep(pair_q.s1, pair_q.s2);
      issue1  = 1'b0;
      issue2  = 1'b0;
      done1   = 1'b0;
      done    = 1'b0;
      state_d = state_q;
      pair_d  = pair_q;
      case (state_q)
         PAIR: begin
            issue1 = pair_q.s1.valid & ~haz1;
            issue2 = issue1 & pair_q.s2.valid & ~haz2 & ~intra;
            done1  = ~pair_q.s1.valid | issue1;
            done   = done1 & (~pair_q.s2.valid | issue2);
            if (done1 && !done) state_d = SECOND;
         end
         SECOND: begin
            // slot 1's result is already in the scoreboard, so only haz2 matters
            issue2 = ~haz2;
            done   = issue2;
         end
         default: ;
      endcase
      if (done) state_d = EMPTY;
      ready = ~bus.flush & ((state_q == EMPTY) | done);
      if (ready && bus.dec_valid) begin
         state_d = PAIR;
         pair_d  = bus.dec_pair;
      end
      if (bus.flush) begin
         issue1  = 1'b0;
         issue2  = 1'b0;
         state_d = EMPTY;
      end
      stall_d = stall_q;
      if ((state_q != EMPTY) && !issue1 && !issue2 && (stall_q != '1))
         stall_d = stall_q + PERF_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         pair_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         pair_q  <= pair_d;
         stall_q <= stall_d;
      end
   end

   scoreboard_cnt_array u_cnt (
      .clk      (clk),
      .reset    (reset),
      .ld1_en   (issue1 & pair_q.s1.wr),
      .ld1_rt   (pair_q.s1.rt),
      .ld1_lat  (pair_q.s1.lat),
      .ld2_en   (issue2 & pair_q.s2.wr),
      .ld2_rt   (pair_q.s2.rt),
      .ld2_lat  (pair_q.s2.lat),
      .busy_vec (busy)
   );

   assign bus.dec_ready    = ready;
   assign bus.issue1       = issue1;
   assign bus.issue2       = issue2;
   assign bus.issue_rt1    = pair_q.s1.rt;
   assign bus.issue_rt2    = pair_q.s2.rt;
   assign bus.busy_vec     = busy;
   assign bus.stall_cycles = stall_q;
endmodule
